// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if
// One bram_sim-style requester port: read/byte-write request, address and
// write data from the requester; per-cycle grant, read-valid tag and shared
// read data back from the arbiter.
//   R_req   : read request
//   W_req   : byte-enable write request, bit 3 = data bits [31:24]
//   addr    : word address
//   W_data  : write data
//   lock    : keep the grant on the next cycle
//   gnt     : access accepted this cycle (combinational)
//   R_valid : R_data holds this requester's read result
//   R_data  : shared read data
interface bram_port_arbiter_if;
  logic        R_req;
  logic [3:0]  W_req;
  logic [31:0] addr;
  logic [31:0] W_data;
  logic        lock;
  logic        gnt;
  logic        R_valid;
  logic [31:0] R_data;

  modport master (
    output R_req, W_req, addr, W_data, lock,
    input  gnt, R_valid, R_data
  );

  modport slave (
    input  R_req, W_req, addr, W_data, lock,
    output gnt, R_valid, R_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one fixed-latency memory port between two requesters (s0, s1) with
// round-robin arbitration, optional grant locking bounded by MAX_BURST, and a
// {valid, id} return pipeline that tags read data with its requester.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   s0, s1     : requester ports (see bram_port_arbiter_if)
//   M_R_req    : memory read request
//   M_W_req    : memory byte-enable write request
//   M_addr     : memory word address
//   M_W_data   : memory write data
//   M_R_data   : memory read data, valid RD_LAT cycles after M_R_req
//   S_R_data   : shared read data (same as M_R_data)
module bram_port_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_port_arbiter_if.slave   s0,
  bram_port_arbiter_if.slave   s1,
  output logic                 M_R_req,
  output logic [3:0]           M_W_req,
  output logic [31:0]          M_addr,
  output logic [31:0]          M_W_data,
  input  logic [31:0]          M_R_data,
  output logic [31:0]          S_R_data
);

  logic              req0, req1;
  logic              req_last, req_other, lock_last;
  logic              last;
  logic              prev_gnt;
  logic [5:0]        bcnt;
  logic              keep, starve;
  logic              gnt_v, gnt_id;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_id;

  assign req0 = s0.R_req | (|s0.W_req);
  assign req1 = s1.R_req | (|s1.W_req);

  assign req_last  = last ? req1 : req0;
  assign req_other = last ? req0 : req1;
  assign lock_last = last ? s1.lock : s0.lock;

  // keep: last cycle's grantee still wants the port and asked to hold it.
  // starve: the hold has run MAX_BURST cycles while the other side waited,
  // so the lock is ignored for this one cycle.
  assign keep   = prev_gnt & req_last & lock_last;
  assign starve = keep & req_other & (bcnt == 6'(MAX_BURST - 1));

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (rst) begin
      if (keep && !starve) begin
        gnt_v  = 1'b1;
        gnt_id = last;
      end else if (req0 && req1) begin
        gnt_v  = 1'b1;
        gnt_id = ~last;
      end else if (req0) begin
        gnt_v  = 1'b1;
        gnt_id = 1'b0;
      end else if (req1) begin
        gnt_v  = 1'b1;
        gnt_id = 1'b1;
      end
    end
  end

  assign s0.gnt = gnt_v & ~gnt_id;
  assign s1.gnt = gnt_v & gnt_id;

  // A write wins over a simultaneous read from the same requester; the read
  // is dropped so no return is tagged for it.
  always_comb begin
    M_R_req  = 1'b0;
    M_W_req  = 4'b0;
    M_addr   = 32'b0;
    M_W_data = 32'b0;
    if (gnt_v) begin
      if (gnt_id) begin
        M_R_req  = s1.R_req & ~(|s1.W_req);
        M_W_req  = s1.W_req;
        M_addr   = s1.addr;
        M_W_data = s1.W_data;
      end else begin
        M_R_req  = s0.R_req & ~(|s0.W_req);
        M_W_req  = s0.W_req;
        M_addr   = s0.addr;
        M_W_data = s0.W_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last     <= 1'b1;
      prev_gnt <= 1'b0;
      bcnt     <= 6'd0;
    end else begin
      prev_gnt <= gnt_v;
      if (gnt_v) last <= gnt_id;
      // Only a locked re-grant against a waiting requester extends the burst.
      if (gnt_v && keep && !starve && req_other) bcnt <= bcnt + 6'd1;
      else                                       bcnt <= 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= M_R_req;
      pipe_id[0] <= M_R_req & gnt_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign s0.R_valid = rst & pipe_v[RD_LAT-1] & ~pipe_id[RD_LAT-1];
  assign s1.R_valid = rst & pipe_v[RD_LAT-1] &  pipe_id[RD_LAT-1];

  assign S_R_data  = M_R_data;
  assign s0.R_data = M_R_data;
  assign s1.R_data = M_R_data;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a bram_sim-style memory
// (RD_LAT=1), a behavioural arbitration/memory model checked every cycle on
// the falling edge, and literal expectations for the key scenarios.
module tb_bram_port_arbiter;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bram_port_arbiter_if s0 ();
  bram_port_arbiter_if s1 ();

  logic        M_R_req;
  logic [3:0]  M_W_req;
  logic [31:0] M_addr;
  logic [31:0] M_W_data;
  logic [31:0] M_R_data;
  logic [31:0] S_R_data;

  bram_port_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0       (s0),
    .s1       (s1),
    .M_R_req  (M_R_req),
    .M_W_req  (M_W_req),
    .M_addr   (M_addr),
    .M_W_data (M_W_data),
    .M_R_data (M_R_data),
    .S_R_data (S_R_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Memory behind the arbiter: registered read (latency 1), byte writes.
  logic [31:0] bram [256];
  initial begin
    for (int i = 0; i < 256; i++) bram[i] = 32'hD000_0000 | 32'(i);
    bram[5] = 32'h1122_3344;
    M_R_data = 32'h0;
    forever begin
      @(posedge clk);
      if (M_R_req) M_R_data <= bram[M_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (M_W_req[b]) bram[M_addr[7:0]][8*b +: 8] = M_W_data[8*b +: 8];
    end
  end

  // Behavioural model: expected memory contents, round-robin/lock state and
  // a queue of pending read returns keyed by the cycle they must appear in.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ret_t;

  logic [31:0] mm [256];
  ret_t        rq [$];
  int          m_last;
  bit          m_prev;
  int          m_run;

  initial begin
    bit          req [2];
    bit          lk  [2];
    bit          rr  [2];
    logic [3:0]  ww  [2];
    logic [31:0] aa  [2];
    logic [31:0] dd  [2];
    int          g;
    bit          keep;
    bit          emr;
    logic [3:0]  emw;
    logic [31:0] ema, emd;
    bit          ev0, ev1;
    logic [31:0] edata;
    ret_t        r;

    for (int i = 0; i < 256; i++) mm[i] = 32'hD000_0000 | 32'(i);
    mm[5] = 32'h1122_3344;
    m_last = 1; m_prev = 0; m_run = 0;

    forever begin
      @(negedge clk);
      if (!rst) begin
        m_last = 1; m_prev = 0; m_run = 0;
        rq.delete();
      end
      rr[0] = s0.R_req;  ww[0] = s0.W_req;  aa[0] = s0.addr;  dd[0] = s0.W_data;  lk[0] = s0.lock;
      rr[1] = s1.R_req;  ww[1] = s1.W_req;  aa[1] = s1.addr;  dd[1] = s1.W_data;  lk[1] = s1.lock;
      req[0] = rr[0] | (|ww[0]);
      req[1] = rr[1] | (|ww[1]);

      g = -1;
      keep = 0;
      if (rst) begin
        keep = m_prev && req[m_last] && lk[m_last];
        if (keep && !(req[1-m_last] && m_run == MAX_BURST - 1)) g = m_last;
        else if (req[0] && req[1]) g = 1 - m_last;
        else if (req[0]) g = 0;
        else if (req[1]) g = 1;
      end

      emr = 0; emw = 4'h0; ema = 32'h0; emd = 32'h0;
      if (g >= 0) begin
        emw = ww[g];
        ema = aa[g];
        emd = dd[g];
        emr = rr[g] && (ww[g] == 4'h0);
      end

      ev0 = 0; ev1 = 0; edata = 32'h0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        edata = r.data;
        if (r.id == 0) ev0 = 1; else ev1 = 1;
      end

      chk("m_s0_gnt",     32'(s0.gnt),     32'(g == 0));
      chk("m_s1_gnt",     32'(s1.gnt),     32'(g == 1));
      chk("m_M_R_req",    32'(M_R_req),    32'(emr));
      chk("m_M_W_req",    32'(M_W_req),    32'(emw));
      chk("m_M_addr",     M_addr,          ema);
      chk("m_M_W_data",   M_W_data,        emd);
      chk("m_s0_R_valid", 32'(s0.R_valid), 32'(ev0));
      chk("m_s1_R_valid", 32'(s1.R_valid), 32'(ev1));
      if (ev0 || ev1) chk("m_S_R_data", S_R_data, edata);

      if (rst) begin
        if (g >= 0) begin
          if (keep && g == m_last && req[1-m_last]) m_run++;
          else                                     m_run = 0;
          m_last = g;
          m_prev = 1;
          if (emr) begin
            r.due  = cyc + RD_LAT;
            r.id   = g;
            r.data = mm[ema[7:0]];
            rq.push_back(r);
          end
          for (int b = 0; b < 4; b++)
            if (emw[b]) mm[ema[7:0]][8*b +: 8] = emd[8*b +: 8];
        end else begin
          m_prev = 0;
          m_run  = 0;
        end
      end
    end
  end

  task automatic set0(input bit r, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input bit l);
    s0.R_req = r; s0.W_req = w; s0.addr = a; s0.W_data = d; s0.lock = l;
  endtask

  task automatic set1(input bit r, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input bit l);
    s1.R_req = r; s1.W_req = w; s1.addr = a; s1.W_data = d; s1.lock = l;
  endtask

  task automatic idle();
    set0(0, 4'h0, 32'h0, 32'h0, 0);
    set1(0, 4'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4:0] iv;
    idle();
    rst = 1'b0;
    tick();
    tick();

    // Reset priority
    set0(1, 4'h0, 32'h10, 32'h0, 0);
    set1(1, 4'h0, 32'h20, 32'h0, 0);
    #1;
    chk("rst_s0_gnt",  32'(s0.gnt),  32'd0);
    chk("rst_s1_gnt",  32'(s1.gnt),  32'd0);
    chk("rst_M_R_req", 32'(M_R_req), 32'd0);
    tick();
    rst = 1'b1;
    mid();
    chk("c0_s0_gnt", 32'(s0.gnt), 32'd1);
    chk("c0_s1_gnt", 32'(s1.gnt), 32'd0);
    tick();
    set0(0, 4'h0, 32'h0, 32'h0, 0);
    mid();
    chk("c1_s1_gnt",     32'(s1.gnt),     32'd1);
    chk("c1_s0_R_valid", 32'(s0.R_valid), 32'd1);
    chk("c1_R_data",     S_R_data,        32'hD000_0010);
    tick();
    idle();
    mid();
    chk("c2_s1_R_valid", 32'(s1.R_valid), 32'd1);
    chk("c2_s0_R_valid", 32'(s0.R_valid), 32'd0);
    chk("c2_R_data",     S_R_data,        32'hD000_0020);

    // Byte write then read-back
    tick();
    set1(0, 4'b0011, 32'd5, 32'hAABB_CCDD, 0);
    mid();
    chk("bw_s1_gnt", 32'(s1.gnt), 32'd1);
    tick();
    set1(1, 4'h0, 32'd5, 32'h0, 0);
    mid();
    chk("bw_bram5", bram[5], 32'h1122_CCDD);
    tick();
    idle();
    mid();
    chk("bw_s1_R_valid", 32'(s1.R_valid), 32'd1);
    chk("bw_R_data",     S_R_data,        32'h1122_CCDD);

    // Lock and starvation bound
    tick();
    set0(1, 4'h0, 32'd7, 32'h0, 1);
    set1(1, 4'h0, 32'd8, 32'h0, 0);
    for (int k = 1; k <= 18; k++) begin
      mid();
      chk($sformatf("burst%0d_s0_gnt", k), 32'(s0.gnt), 32'((k <= 16) || (k == 18)));
      chk($sformatf("burst%0d_s1_gnt", k), 32'(s1.gnt), 32'(k == 17));
      tick();
      if (k == 17) set1(0, 4'h0, 32'h0, 32'h0, 0);
    end
    idle();

    // Dropping lock re-enters round-robin in the same cycle
    tick();
    set0(1, 4'h0, 32'd9, 32'h0, 1);
    mid();
    chk("lk_s0_gnt", 32'(s0.gnt), 32'd1);
    tick();
    set0(1, 4'h0, 32'd9, 32'h0, 0);
    set1(1, 4'h0, 32'h0A, 32'h0, 0);
    mid();
    chk("lkrel_s1_gnt", 32'(s1.gnt), 32'd1);
    chk("lkrel_s0_gnt", 32'(s0.gnt), 32'd0);
    tick();
    idle();

    // Read and write in the same granted cycle
    tick();
    set0(1, 4'hF, 32'd3, 32'h1234_5678, 0);
    mid();
    chk("col_M_R_req", 32'(M_R_req), 32'd0);
    chk("col_M_W_req", 32'(M_W_req), 32'hF);
    chk("col_s0_gnt",  32'(s0.gnt),  32'd1);
    tick();
    idle();
    mid();
    chk("col_s0_R_valid", 32'(s0.R_valid), 32'd0);
    chk("col_bram3",      bram[3],         32'h1234_5678);

    // Reset in the middle of a read
    tick();
    set1(1, 4'h0, 32'h20, 32'h0, 0);
    mid();
    chk("mr_s1_gnt", 32'(s1.gnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_rst_s1_gnt",  32'(s1.gnt),  32'd0);
    chk("mr_rst_M_R_req", 32'(M_R_req), 32'd0);
    chk("mr_rst_M_addr",  M_addr,       32'd0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("mr_after_s1_R_valid", 32'(s1.R_valid), 32'd0);
      tick();
    end

    // Mixed vectors, checked by the model
    for (int i = 0; i < 24; i++) begin
      iv = 5'(i);
      set0(iv[0], (i % 5 == 0) ? (4'(i % 16) | 4'h1) : 4'h0,
           32'(8'h30 + i % 8), 32'hCAFE_0000 + 32'(i), iv[1]);
      set1(iv[2] ^ iv[0], (i % 3 == 0) ? 4'hC : 4'h0,
           32'(8'h40 + i % 4), 32'hBEEF_0000 + 32'(i), iv[3]);
      tick();
    end
    idle();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
